// File: rtl/pma_region_pkg.sv
// Shared types for the runtime-programmable PMA table.
// PMA_REGION_LOCK_EN (optional define) keeps the per-rule lock bit; otherwise it is forced to 0.
package pma_region_pkg;

  localparam int unsigned PMA_MAX_RULES = 16;

  // Packed so that an ATTR write/read maps wdata[3:0] = {nonidem, exec, cached, lock}
  typedef struct packed {
    logic nonidem;
    logic exec;
    logic cached;
    logic lock;
  } pma_attr_t;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] length;
    pma_attr_t   attr;
  } pma_rule_t;

  typedef enum logic [1:0] {
    PMA_BASE   = 2'd0,
    PMA_LENGTH = 2'd1,
    PMA_ATTR   = 2'd2,
    PMA_COMMIT = 2'd3
  } pma_field_e;

  function automatic pma_attr_t pma_sanitize_attr(input pma_attr_t attr);
    pma_attr_t res;
`ifdef PMA_REGION_LOCK_EN
    res = attr;
`else
    res      = attr;
    res.lock = 1'b0;
`endif
    return res;
  endfunction

  function automatic pma_rule_t pma_sanitize_rule(input pma_rule_t rule);
    pma_rule_t res;
    res      = rule;
    res.attr = pma_sanitize_attr(rule.attr);
    return res;
  endfunction

endpackage

// File: rtl/pma_rule_match.sv
// Single-rule, single-address range compare with attribute gating.
// The subtraction form keeps a base+length overflow from wrapping into low addresses.
module pma_rule_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] length,
  input  logic                 attr_nonidem,
  input  logic                 attr_exec,
  input  logic                 attr_cached,
  output logic                 match,
  output logic                 nonidem,
  output logic                 exec,
  output logic                 cached
);

  logic [AddrWidth-1:0] offset_s;

  assign offset_s = addr - base;
  assign match    = (addr >= base) && (offset_s < length);
  assign nonidem  = match & attr_nonidem;
  assign exec     = match & attr_exec;
  assign cached   = match & attr_cached;

endmodule

// File: rtl/pma_region_table.sv
// PMA rule table: shadow/active rule sets, register-style config port with atomic commit,
// and NrPorts registered lookups. Optional define PMA_REGION_LOCK_EN enables sticky rule lock.
module pma_region_table
  import pma_region_pkg::*;
#(
  parameter int unsigned             NrRules      = 8,
  parameter int unsigned             NrPorts      = 2,
  parameter int unsigned             AddrWidth    = 64,
  parameter pma_rule_t [NrRules-1:0] DefaultRules = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cfg_req_i,
  input  logic                              cfg_we_i,
  input  logic [3:0]                        cfg_idx_i,
  input  pma_field_e                        cfg_field_i,
  input  logic [AddrWidth-1:0]              cfg_wdata_i,
  output logic                              cfg_gnt_o,
  output logic                              cfg_rvalid_o,
  output logic [AddrWidth-1:0]              cfg_rdata_o,
  output logic                              cfg_err_o,
  input  logic [NrPorts-1:0]                lookup_valid_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0] lookup_addr_i,
  output logic [NrPorts-1:0]                lookup_valid_o,
  output logic [NrPorts-1:0]                lookup_hit_o,
  output logic [NrPorts-1:0]                lookup_nonidem_o,
  output logic [NrPorts-1:0]                lookup_exec_o,
  output logic [NrPorts-1:0]                lookup_cached_o
);

  pma_rule_t            shadow_s [PMA_MAX_RULES];
  pma_rule_t            active_s [PMA_MAX_RULES];
  pma_rule_t            sel_shadow_s;
  logic                 idx_ok_s, locked_s, commit_s, wr_s, err_s;
  logic [AddrWidth-1:0] rdata_s;
  logic                 rvalid_r, err_r;
  logic [AddrWidth-1:0] rdata_r;

  assign cfg_gnt_o    = cfg_req_i;
  assign sel_shadow_s = shadow_s[cfg_idx_i];
  assign locked_s     = active_s[cfg_idx_i].attr.lock;

  // Decode the config access into commit/write strobes, error and read data
  always_comb begin
    idx_ok_s = ({1'b0, cfg_idx_i} < 5'(NrRules));
    commit_s = 1'b0;
    wr_s     = 1'b0;
    err_s    = 1'b0;
    rdata_s  = '0;
    if (!cfg_req_i) begin
      commit_s = 1'b0;
    end else if (cfg_we_i && (cfg_field_i == PMA_COMMIT)) begin
      commit_s = 1'b1;
    end else if (!idx_ok_s) begin
      err_s = 1'b1;
    end else if (cfg_we_i) begin
      if (locked_s) begin
        err_s = 1'b1;
      end else begin
        wr_s = 1'b1;
      end
    end else begin
      case (cfg_field_i)
        PMA_BASE:   rdata_s = AddrWidth'(sel_shadow_s.base);
        PMA_LENGTH: rdata_s = AddrWidth'(sel_shadow_s.length);
        PMA_ATTR:   rdata_s = AddrWidth'(sel_shadow_s.attr);
        default:    rdata_s = '0;
      endcase
    end
  end

  // Config response register; reset drops a response still in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= cfg_req_i;
      err_r    <= err_s;
      rdata_r  <= rdata_s;
    end
  end

  assign cfg_rvalid_o = rvalid_r;
  assign cfg_err_o    = err_r;
  assign cfg_rdata_o  = rdata_r;

  for (genvar g = 0; g < PMA_MAX_RULES; g++) begin : g_rule
    if (g < NrRules) begin : g_used
      pma_rule_t shadow_r, active_r, init_s;
      logic      sel_s, keep_s;

      assign init_s = pma_sanitize_rule(DefaultRules[g]);
      assign sel_s  = wr_s && (cfg_idx_i == 4'(g));
`ifdef PMA_REGION_LOCK_EN
      assign keep_s = active_r.attr.lock;
`else
      assign keep_s = 1'b0;
`endif

      // Field writes land in shadow; commit publishes shadow unless the active rule is locked
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          shadow_r <= init_s;
          active_r <= init_s;
        end else if (commit_s) begin
          if (keep_s) begin
            shadow_r <= active_r;
          end else begin
            active_r <= shadow_r;
          end
        end else if (sel_s) begin
          case (cfg_field_i)
            PMA_BASE:   shadow_r.base   <= 64'(cfg_wdata_i);
            PMA_LENGTH: shadow_r.length <= 64'(cfg_wdata_i);
            PMA_ATTR:   shadow_r.attr   <= pma_sanitize_attr(pma_attr_t'(cfg_wdata_i[3:0]));
            default:    shadow_r        <= shadow_r;
          endcase
        end
      end

      assign shadow_s[g] = shadow_r;
      assign active_s[g] = active_r;
    end else begin : g_unused
      assign shadow_s[g] = '0;
      assign active_s[g] = '0;
    end
  end

  logic [NrPorts-1:0][NrRules-1:0] m_hit_s, m_nonidem_s, m_exec_s, m_cached_s;
  logic [NrPorts-1:0]              valid_r, hit_r, nonidem_r, exec_r, cached_r;

  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    for (genvar r = 0; r < NrRules; r++) begin : g_match
      pma_rule_match #(.AddrWidth(AddrWidth)) u_match (
        .addr         (lookup_addr_i[p]),
        .base         (active_s[r].base[AddrWidth-1:0]),
        .length       (active_s[r].length[AddrWidth-1:0]),
        .attr_nonidem (active_s[r].attr.nonidem),
        .attr_exec    (active_s[r].attr.exec),
        .attr_cached  (active_s[r].attr.cached),
        .match        (m_hit_s[p][r]),
        .nonidem      (m_nonidem_s[p][r]),
        .exec         (m_exec_s[p][r]),
        .cached       (m_cached_s[p][r])
      );
    end
  end

  // Lookup result register: OR-reduce all matching rules per port
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r   <= '0;
      hit_r     <= '0;
      nonidem_r <= '0;
      exec_r    <= '0;
      cached_r  <= '0;
    end else begin
      valid_r <= lookup_valid_i;
      for (int p = 0; p < NrPorts; p++) begin
        hit_r[p]     <= lookup_valid_i[p] & (|m_hit_s[p]);
        nonidem_r[p] <= lookup_valid_i[p] & (|m_nonidem_s[p]);
        exec_r[p]    <= lookup_valid_i[p] & (|m_exec_s[p]);
        cached_r[p]  <= lookup_valid_i[p] & (|m_cached_s[p]);
      end
    end
  end

  assign lookup_valid_o   = valid_r;
  assign lookup_hit_o     = hit_r;
  assign lookup_nonidem_o = nonidem_r;
  assign lookup_exec_o    = exec_r;
  assign lookup_cached_o  = cached_r;

endmodule

// File: tb/tb_pma_region_table.sv
// Self-checking bench for pma_region_table against a range-list reference model.
// Honors PMA_REGION_LOCK_EN when defined for the build.
`timescale 1ns/1ps
module tb_pma_region_table;
  import pma_region_pkg::*;

  localparam int NR = 8;
  localparam int NP = 2;
  localparam int AW = 64;
`ifdef PMA_REGION_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  localparam pma_rule_t R0 = '{base: 64'h8000_0000, length: 64'h4000_0000,
                               attr: '{nonidem: 1'b0, exec: 1'b1, cached: 1'b1, lock: 1'b0}};
  localparam pma_rule_t [NR-1:0] DEFS = {{((NR-1)*$bits(pma_rule_t)){1'b0}}, R0};

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_req = 1'b0, cfg_we = 1'b0;
  logic [3:0]           cfg_idx = 4'd0;
  pma_field_e           cfg_field = PMA_BASE;
  logic [AW-1:0]        cfg_wdata = '0;
  logic                 cfg_gnt, cfg_rvalid, cfg_err;
  logic [AW-1:0]        cfg_rdata;
  logic [NP-1:0]        lk_valid = '0;
  logic [NP-1:0][AW-1:0] lk_addr = '0;
  logic [NP-1:0]        lk_valid_o, lk_hit, lk_ni, lk_ex, lk_ca;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: attr nibble = {nonidem, exec, cached, lock}
  logic [63:0] m_sh_base [NR], m_sh_len [NR], m_ac_base [NR], m_ac_len [NR];
  logic [3:0]  m_sh_attr [NR], m_ac_attr [NR];

  pma_region_table #(.NrRules(NR), .NrPorts(NP), .AddrWidth(AW), .DefaultRules(DEFS)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata), .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err), .lookup_valid_i(lk_valid), .lookup_addr_i(lk_addr),
    .lookup_valid_o(lk_valid_o), .lookup_hit_o(lk_hit), .lookup_nonidem_o(lk_ni),
    .lookup_exec_o(lk_ex), .lookup_cached_o(lk_ca)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_sh_base[i] = '0; m_sh_len[i] = '0; m_sh_attr[i] = '0;
    end
    m_sh_base[0] = 64'h8000_0000; m_sh_len[0] = 64'h4000_0000; m_sh_attr[0] = 4'b0110;
    for (int i = 0; i < NR; i++) begin
      m_ac_base[i] = m_sh_base[i]; m_ac_len[i] = m_sh_len[i]; m_ac_attr[i] = m_sh_attr[i];
    end
  endtask

  task automatic model_cfg(input bit we, input int idx, input pma_field_e f, input logic [63:0] wd,
                           output logic err, output logic [63:0] rd);
    err = 1'b0; rd = '0;
    if (we && f == PMA_COMMIT) begin
      for (int i = 0; i < NR; i++) begin
        if (LOCK_EN && m_ac_attr[i][0]) begin
          m_sh_base[i] = m_ac_base[i]; m_sh_len[i] = m_ac_len[i]; m_sh_attr[i] = m_ac_attr[i];
        end else begin
          m_ac_base[i] = m_sh_base[i]; m_ac_len[i] = m_sh_len[i]; m_ac_attr[i] = m_sh_attr[i];
        end
      end
    end else if (idx >= NR) begin
      err = 1'b1;
    end else if (we) begin
      if (LOCK_EN && m_ac_attr[idx][0]) err = 1'b1;
      else if (f == PMA_BASE) m_sh_base[idx] = wd;
      else if (f == PMA_LENGTH) m_sh_len[idx] = wd;
      else m_sh_attr[idx] = LOCK_EN ? wd[3:0] : {wd[3:1], 1'b0};
    end else begin
      if (f == PMA_BASE) rd = m_sh_base[idx];
      else if (f == PMA_LENGTH) rd = m_sh_len[idx];
      else if (f == PMA_ATTR) rd = {60'd0, m_sh_attr[idx]};
      else rd = '0;
    end
  endtask

  // Expected {valid, hit, nonidem, exec, cached}; 65-bit end so nothing wraps
  task automatic model_lookup(input logic [63:0] a, output logic [4:0] e);
    logic [64:0] lo, hi;
    logic h, ni, ex, ca;
    h = 1'b0; ni = 1'b0; ex = 1'b0; ca = 1'b0;
    for (int i = 0; i < NR; i++) begin
      lo = {1'b0, m_ac_base[i]};
      hi = lo + {1'b0, m_ac_len[i]};
      if ({1'b0, a} >= lo && {1'b0, a} < hi) begin
        h = 1'b1; ni |= m_ac_attr[i][3]; ex |= m_ac_attr[i][2]; ca |= m_ac_attr[i][1];
      end
    end
    e = {1'b1, h, ni, ex, ca};
  endtask

  // One config access; act/exp = {gnt, rvalid, err}
  task automatic cfg_op(input bit we, input int idx, input pma_field_e f, input logic [63:0] wd,
                        output logic [2:0] act, output logic [2:0] exp,
                        output logic [63:0] rd, output logic [63:0] erd);
    logic eerr;
    model_cfg(we, idx, f, wd, eerr, erd);
    cfg_req = 1'b1; cfg_we = we; cfg_idx = 4'(idx); cfg_field = f; cfg_wdata = wd;
    #1 act[2] = cfg_gnt;
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    act[1:0] = {cfg_rvalid, cfg_err};
    rd = cfg_rdata;
    exp = {2'b11, eerr};
  endtask

  task automatic lookup_one(input int p, input logic [63:0] a, output logic [4:0] act, output logic [4:0] e);
    model_lookup(a, e);
    lk_valid = '0; lk_valid[p] = 1'b1; lk_addr[p] = a;
    @(posedge clk); #1;
    act = {lk_valid_o[p], lk_hit[p], lk_ni[p], lk_ex[p], lk_ca[p]};
    lk_valid = '0;
  endtask

  function automatic logic [63:0] pick_addr();
    int r, k;
    r = $urandom_range(0, NR - 1);
    k = $urandom_range(0, 4);
    case (k)
      0: return m_ac_base[r] - 64'd1;
      1: return m_ac_base[r];
      2: return m_ac_base[r] + m_ac_len[r] - 64'd1;
      3: return m_ac_base[r] + m_ac_len[r];
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cfg_gnt, cfg_rvalid, cfg_err, cfg_rdata, lk_valid_o, lk_hit, lk_ni, lk_ex, lk_ca} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got rv=%b err=%b rdata=%h lkv=%b hit=%b, required all 0",
                              cfg_rvalid, cfg_err, cfg_rdata, lk_valid_o, lk_hit); end
    rst = 1'b0;
    model_reset();
    begin
      logic [4:0] a, e;
      lookup_one(0, 64'h8000_1000, a, e);
      n_checks++;
      if (a !== 5'b11011) begin n_fail++; $display("FAIL reset_default_rule: got %b required %b", a, 5'b11011); end
      n_checks++;
      if (a !== e) begin n_fail++; $display("FAIL reset_default_model: got %b required %b", a, e); end
    end
  endtask

  task automatic test_shadow_commit();
    logic [2:0] act, exp; logic [63:0] rd, erd; logic [4:0] a, e; logic eerr;
    cfg_op(1'b1, 1, PMA_BASE, 64'h1_0000, act, exp, rd, erd);
    n_checks++; if (act !== exp) begin n_fail++; $display("FAIL wr_base: got %b required %b", act, exp); end
    cfg_op(1'b0, 1, PMA_BASE, 64'h0, act, exp, rd, erd);
    n_checks++; if ({act, rd} !== {exp, 64'h1_0000}) begin n_fail++; $display("FAIL rd_after_wr: got %b/%h required %b/%h", act, rd, exp, 64'h1_0000); end
    cfg_op(1'b1, 1, PMA_LENGTH, 64'h1_0000, act, exp, rd, erd);
    cfg_op(1'b1, 1, PMA_ATTR, 64'h4, act, exp, rd, erd);
    cfg_op(1'b0, 1, PMA_ATTR, 64'h0, act, exp, rd, erd);
    n_checks++; if ({act, rd} !== {exp, erd}) begin n_fail++; $display("FAIL rd_attr: got %b/%h required %b/%h", act, rd, exp, erd); end
    lookup_one(1, 64'h1_8000, a, e);
    n_checks++; if (a !== 5'b10000 || a !== e) begin n_fail++; $display("FAIL shadow_not_active: got %b required %b", a, 5'b10000); end
    // Commit and lookup sampled on the same edge: lookup must see the old table
    model_lookup(64'h1_8000, e);
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_field = PMA_COMMIT; cfg_idx = 4'd0; cfg_wdata = '0;
    lk_valid = 2'b01; lk_addr[0] = 64'h1_8000;
    @(posedge clk); #1;
    cfg_req = 1'b0; cfg_we = 1'b0;
    a = {lk_valid_o[0], lk_hit[0], lk_ni[0], lk_ex[0], lk_ca[0]};
    n_checks++; if (a !== e) begin n_fail++; $display("FAIL commit_cycle_lookup: got %b required %b", a, e); end
    n_checks++; if ({cfg_rvalid, cfg_err} !== 2'b10) begin n_fail++; $display("FAIL commit_resp: got %b required %b", {cfg_rvalid, cfg_err}, 2'b10); end
    model_cfg(1'b1, 0, PMA_COMMIT, '0, eerr, erd);
    model_lookup(64'h1_8000, e);
    @(posedge clk); #1;
    lk_valid = '0;
    a = {lk_valid_o[0], lk_hit[0], lk_ni[0], lk_ex[0], lk_ca[0]};
    n_checks++; if (a !== 5'b11010 || a !== e) begin n_fail++; $display("FAIL post_commit_lookup: got %b required %b", a, 5'b11010); end
  endtask

  task automatic test_boundaries();
    logic [2:0] act, exp; logic [63:0] rd, erd; logic [4:0] a, e;
    logic [63:0] addrs [6];
    addrs = '{64'h1_FFFF, 64'h2_0000, 64'hFFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_EFFF};
    cfg_op(1'b1, 3, PMA_BASE, 64'hFFFF_FFFF_FFFF_F000, act, exp, rd, erd);
    cfg_op(1'b1, 3, PMA_LENGTH, 64'h2000, act, exp, rd, erd);
    cfg_op(1'b1, 3, PMA_ATTR, 64'h8, act, exp, rd, erd);
    cfg_op(1'b1, 0, PMA_COMMIT, 64'h0, act, exp, rd, erd);
    n_checks++; if (act !== exp) begin n_fail++; $display("FAIL wrap_commit: got %b required %b", act, exp); end
    for (int i = 0; i < 6; i++) begin
      lookup_one(i % NP, addrs[i], a, e);
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL boundary_%0d addr %h: got %b required %b", i, addrs[i], a, e); end
    end
  endtask

  task automatic test_lock();
    logic [2:0] act, exp; logic [63:0] rd, erd; logic [4:0] a, e;
    cfg_op(1'b1, 2, PMA_BASE, 64'h4000_0000, act, exp, rd, erd);
    cfg_op(1'b1, 2, PMA_LENGTH, 64'h1000, act, exp, rd, erd);
    cfg_op(1'b1, 2, PMA_ATTR, 64'h3, act, exp, rd, erd);
    cfg_op(1'b1, 0, PMA_COMMIT, 64'h0, act, exp, rd, erd);
    cfg_op(1'b0, 2, PMA_ATTR, 64'h0, act, exp, rd, erd);
    n_checks++; if ({act, rd} !== {exp, (LOCK_EN ? 64'h3 : 64'h2)}) begin n_fail++; $display("FAIL lock_attr_rd: got %b/%h required %b/%h", act, rd, exp, erd); end
    cfg_op(1'b1, 2, PMA_BASE, 64'h5000_0000, act, exp, rd, erd);
    n_checks++; if (act !== {2'b11, LOCK_EN}) begin n_fail++; $display("FAIL lock_wr_err: got %b required %b", act, {2'b11, LOCK_EN}); end
    cfg_op(1'b0, 2, PMA_BASE, 64'h0, act, exp, rd, erd);
    n_checks++; if ({act, rd} !== {exp, erd}) begin n_fail++; $display("FAIL lock_base_rd: got %b/%h required %b/%h", act, rd, exp, erd); end
    cfg_op(1'b1, 2, PMA_ATTR, 64'h0, act, exp, rd, erd);
    n_checks++; if (act !== exp) begin n_fail++; $display("FAIL lock_clear_attempt: got %b required %b", act, exp); end
    cfg_op(1'b1, 0, PMA_COMMIT, 64'h0, act, exp, rd, erd);
    lookup_one(0, 64'h4000_0800, a, e);
    n_checks++; if (a !== e) begin n_fail++; $display("FAIL lock_old_range: got %b required %b", a, e); end
    lookup_one(1, 64'h5000_0800, a, e);
    n_checks++; if (a !== e) begin n_fail++; $display("FAIL lock_new_range: got %b required %b", a, e); end
    cfg_op(1'b0, 2, PMA_ATTR, 64'h0, act, exp, rd, erd);
    n_checks++; if ({act, rd} !== {exp, erd}) begin n_fail++; $display("FAIL lock_refresh_rd: got %b/%h required %b/%h", act, rd, exp, erd); end
  endtask

  task automatic test_range_err();
    logic [2:0] act, exp; logic [63:0] rd, erd;
    int idxs [3];
    idxs = '{NR, NR, 15};
    for (int i = 0; i < 3; i++) begin
      cfg_op(i == 1, idxs[i], (i == 2) ? PMA_ATTR : PMA_LENGTH, 64'hDEAD, act, exp, rd, erd);
      n_checks++; if (act !== 3'b111 || act !== exp) begin n_fail++; $display("FAIL range_err_%0d: got %b required %b", i, act, 3'b111); end
    end
  endtask

  task automatic test_reset_inflight();
    logic [2:0] act, exp; logic [63:0] rd, erd; logic [4:0] a, e;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_idx = 4'd1; cfg_field = PMA_BASE;
    @(posedge clk); #1;
    n_checks++; if (cfg_rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rvalid: got %b required 1", cfg_rvalid); end
    rst = 1'b1; lk_valid = 2'b11; lk_addr[0] = 64'h8000_0000; lk_addr[1] = 64'h1_0000;
    @(posedge clk); #1;
    n_checks++; if ({cfg_rvalid, cfg_err, lk_valid_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_drop: got %b required %b", {cfg_rvalid, cfg_err, lk_valid_o}, 4'b0000); end
    rst = 1'b0; cfg_req = 1'b0; lk_valid = '0;
    model_reset();
    cfg_op(1'b0, 1, PMA_BASE, 64'h0, act, exp, rd, erd);
    n_checks++; if ({act, rd} !== {exp, 64'h0}) begin n_fail++; $display("FAIL reset_shadow_default: got %b/%h required %b/%h", act, rd, exp, 64'h0); end
    cfg_op(1'b1, 2, PMA_BASE, 64'h7000, act, exp, rd, erd);
    n_checks++; if (act !== 3'b110) begin n_fail++; $display("FAIL reset_unlock: got %b required %b", act, 3'b110); end
    lookup_one(1, 64'h1_8000, a, e);
    n_checks++; if (a !== 5'b10000 || a !== e) begin n_fail++; $display("FAIL reset_active_default: got %b required %b", a, 5'b10000); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] act, exp; logic [63:0] rd, erd;
    logic [4:0] e [NP];
    logic [4:0] a;
    logic [NP-1:0] v;
    for (int i = 0; i < NR; i++) begin
      cfg_op(1'b1, i, PMA_BASE, (i % 2 == 0) ? {32'h0, $urandom} : {$urandom, $urandom}, act, exp, rd, erd);
      cfg_op(1'b1, i, PMA_LENGTH, ($urandom_range(0, 5) == 0) ? 64'h0 : 64'($urandom_range(1, 32'h0010_0000)), act, exp, rd, erd);
      cfg_op(1'b1, i, PMA_ATTR, 64'($urandom_range(0, 15)) & 64'hE, act, exp, rd, erd);
      n_checks++; if (act !== exp) begin n_fail++; $display("FAIL rand_wr_%0d: got %b required %b", i, act, exp); end
    end
    cfg_op(1'b1, 0, PMA_COMMIT, 64'h0, act, exp, rd, erd);
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < NP; p++) begin
        v[p] = (c < 200) ? 1'b1 : 1'($urandom_range(0, 1));
        lk_addr[p] = pick_addr();
        model_lookup(lk_addr[p], e[p]);
      end
      lk_valid = v;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        a = {lk_valid_o[p], lk_hit[p], lk_ni[p], lk_ex[p], lk_ca[p]};
        n_checks++;
        if (v[p] ? (a !== e[p]) : (a[4] !== 1'b0)) begin
          n_fail++; $display("FAIL b2b c%0d p%0d addr %h: got %b required %b", c, p, lk_addr[p], a, v[p] ? e[p] : 5'b00000);
        end
      end
    end
    lk_valid = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_shadow_commit();
    test_boundaries();
    test_lock();
    test_range_err();
    test_reset_inflight();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule

// File: doc/pma_region_table.md
# pma_region_table

Runtime-programmable physical memory attribute (PMA) table. It replaces fixed non-idempotent, execute and cached region lists with a configurable number of rules. Rules are written through a register-style config port into a shadow copy and committed atomically. It sits between the CSR/debug configuration path and the frontend/LSU address checks. It serves several lookup ports with one-cycle registered latency.

## Interface
- NrRules, 8, number of rules (1..16)
- NrPorts, 2, lookup ports (port 0 fetch, port 1 data, extra ports generic)
- AddrWidth, 64, physical address width
- DefaultRules, all-zero, pma_rule_t array[NrRules] loaded into shadow and active on reset
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_req_i  in  1  config access request
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_idx_i  in  4  rule index
- cfg_field_i  in  2  pma_field_e: BASE, LENGTH, ATTR, COMMIT
- cfg_wdata_i  in  AddrWidth  write data (ATTR uses bits [3:0])
- cfg_gnt_o  out  1  access accepted
- cfg_rvalid_o  out  1  response valid, one cycle after grant
- cfg_rdata_o  out  AddrWidth  read data (shadow copy)
- cfg_err_o  out  1  error, qualifies cfg_rvalid_o
- lookup_valid_i  in  NrPorts  lookup request per port
- lookup_addr_i  in  NrPorts×AddrWidth  lookup address
- lookup_valid_o  out  NrPorts  result valid
- lookup_hit_o  out  NrPorts  address matched at least one rule
- lookup_nonidem_o / lookup_exec_o / lookup_cached_o  out  NrPorts each  OR of the attribute over all matching rules

## Operation
- Rule: base, length, attr {nonidem, exec, cached, lock}. Length 0 disables the rule.
- Match condition: addr >= base && (addr - base) < length. All arithmetic is unsigned at AddrWidth. The subtraction form means base+length overflow never wraps into low addresses.
- Attributes are ORed across matching rules. A miss returns all attributes 0.
- Lookups always use the active table, never the shadow.
- cfg_gnt_o = cfg_req_i. Every access is accepted in the cycle it is presented.
- Writes to BASE, LENGTH or ATTR update shadow[idx] only.
- A write with field COMMIT copies every shadow rule into the active table in one cycle. It ignores idx and wdata.
- Reads return shadow[idx].field. ATTR is zero-extended. A read of COMMIT returns 0.
- cfg_err_o = 1, and shadow is unchanged, when any of these hold:
  - idx >= NrRules, on read or write.
  - A write targets a rule whose active lock bit is 1.
- Lock is sticky. Once committed, a locked rule stays locked until reset.
- A commit never overwrites a locked active rule. That rule's shadow entry is refreshed from active during the commit.

## Timing
- Lookup: inputs are sampled at edge N; results are registered and valid after edge N+1. Throughput is one lookup per port per cycle. lookup_valid_o follows lookup_valid_i delayed by one cycle.
- Config: response (rvalid, rdata, err) appears the cycle after the grant.
- Commit accepted at edge N:
  - Lookups sampled at edge N use the old table.
  - Lookups sampled at edge N+1 onward use the new table.
- Write then read of the same field in consecutive cycles returns the new value.
- Reset:
  - All outputs are 0.
  - Shadow and active both load DefaultRules.
  - An in-flight config response or lookup result is dropped.

## Configuration
- PMA_REGION_LOCK_EN defined: lock bit is stored and enforced as above.
- Without it:
  - Lock bit is forced to 0 in storage and reads back 0.
  - No write ever errors because of lock. Only the range error remains.
  - The lock-preservation logic in commit is removed.

## Structure
- Package pma_region_pkg holds:
  - pma_attr_t, pma_rule_t and pma_field_e.
  - Constant PMA_MAX_RULES = 16.
- Sub-module pma_rule_match: combinational single-rule, single-address compare. It outputs match plus the gated attributes. It is instantiated NrRules×NrPorts times, with the OR-reduce and output register in the top level.

## Test plan
- Reset with DefaultRules[0] = {base 0x8000_0000, length 0x4000_0000, cached+exec}; lookup 0x8000_1000 -> one cycle later hit=1, cached=1, exec=1, nonidem=0.
- Write rule 1 {base 0x1_0000, length 0x1_0000, exec} without commit; lookup 0x1_8000 -> hit=0; issue commit; lookup in the commit cycle -> hit=0; lookup in the next cycle -> hit=1, exec=1.
- Boundary addresses for rule 1: 0x1_FFFF -> hit=1; 0x2_0000 -> hit=0. Wrap case: rule base 0xFFFF_FFFF_FFFF_F000, length 0x2000; lookup 0x0 -> hit=0.
- With PMA_REGION_LOCK_EN: set lock on rule 2 and commit; write BASE of rule 2 -> err=1 and readback unchanged; commit again -> rule 2 unchanged. Without the macro: the same write gives err=0 and the value is updated.
- Read or write with idx = NrRules -> err=1. Synchronous reset asserted in the cycle after a grant -> rvalid=0 and the table returns to defaults.
- Two ports issue back-to-back lookups on every cycle with random addresses against a reference model -> results match, one per cycle per port, with no bubbles.
